// File: rtl/tex_agent.sv
// tex_agent: texture request agent in front of the texture unit.
//
// Accepts texture instructions from the execute stage and forwards their
// coordinates to the texture unit. The writeback metadata (warp, uuid,
// destination register, lane mask) is parked in a small tag table, and the
// table index travels with the request as its tag. When the texel response
// comes back, the agent rebuilds a commit packet from the table entry and the
// texels. Up to DEPTH requests can be outstanding.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   exe_*                 instruction from the execute stage (valid/ready)
//   tex_req_*             coordinate request to the texture unit (valid/ready)
//   tex_rsp_*             texel response from the texture unit (valid/ready)
//   commit_*              rebuilt writeback packet (valid/ready)
//   pending_cnt           number of occupied table entries
//   tag_err               sticky: a response named a table entry that was free
module tex_agent #(
  parameter int NUM_LANES = 4,
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int UUID_W    = 44,
  parameter int RD_W      = 5,
  parameter int LOD_W     = 4,
  parameter int STAGE_W   = 1,
  localparam int WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        exe_valid,
  input  logic [WID_W-1:0]            exe_wid,
  input  logic [UUID_W-1:0]           exe_uuid,
  input  logic [RD_W-1:0]             exe_rd,
  input  logic [NUM_LANES-1:0]        exe_mask,
  input  logic [2*NUM_LANES*32-1:0]   exe_coords,
  input  logic [NUM_LANES*LOD_W-1:0]  exe_lod,
  input  logic [STAGE_W-1:0]          exe_stage,
  output logic                        exe_ready,

  output logic                        tex_req_valid,
  output logic [NUM_LANES-1:0]        tex_req_mask,
  output logic [2*NUM_LANES*32-1:0]   tex_req_coords,
  output logic [NUM_LANES*LOD_W-1:0]  tex_req_lod,
  output logic [STAGE_W-1:0]          tex_req_stage,
  output logic [TAG_W-1:0]            tex_req_tag,
  input  logic                        tex_req_ready,

  input  logic                        tex_rsp_valid,
  input  logic [NUM_LANES*32-1:0]     tex_rsp_texels,
  input  logic [TAG_W-1:0]            tex_rsp_tag,
  output logic                        tex_rsp_ready,

  output logic                        commit_valid,
  output logic [WID_W-1:0]            commit_wid,
  output logic [UUID_W-1:0]           commit_uuid,
  output logic [RD_W-1:0]             commit_rd,
  output logic [NUM_LANES-1:0]        commit_mask,
  output logic [NUM_LANES*32-1:0]     commit_data,
  input  logic                        commit_ready,

  output logic [TAG_W:0]              pending_cnt,
  output logic                        tag_err
);

  typedef struct packed {
    logic [WID_W-1:0]     wid;
    logic [UUID_W-1:0]    uuid;
    logic [RD_W-1:0]      rd;
    logic [NUM_LANES-1:0] mask;
  } meta_t;

  // Table state: valid bits are reset, metadata is not.
  logic [DEPTH-1:0] valid_q, valid_d;
  meta_t            table_q [DEPTH];
  logic [TAG_W:0]   cnt_q, cnt_d;

  // Commit output register.
  logic                    commit_valid_q, commit_valid_d;
  meta_t                   commit_meta_q;
  logic [NUM_LANES*32-1:0] commit_data_q;
  logic                    tag_err_q, tag_err_d;

  logic             full;
  logic [TAG_W-1:0] free_tag;
  logic             req_fire;
  logic             rsp_fire;
  logic             rsp_hit;
  logic             rsp_free;
  meta_t            req_meta;

  // Full is taken from the registered count only, so a slot freed by a
  // response this cycle cannot be reused before the next cycle.
  assign full = (cnt_q == (TAG_W+1)'(DEPTH));

  // Lowest-index free entry. When the table is full the value is unused.
  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    free_tag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_tag = TAG_W'(i);
    end
  end

  // Request path is a pure pass-through; only the tag is generated here.
  assign tex_req_valid  = exe_valid & ~full;
  assign exe_ready      = tex_req_ready & ~full;
  assign tex_req_mask   = exe_mask;
  assign tex_req_coords = exe_coords;
  assign tex_req_lod    = exe_lod;
  assign tex_req_stage  = exe_stage;
  assign tex_req_tag    = free_tag;

  assign req_fire = tex_req_valid & tex_req_ready;

  // A response is taken whenever the commit register is empty or draining.
  assign tex_rsp_ready = ~commit_valid_q | commit_ready;
  assign rsp_fire      = tex_rsp_valid & tex_rsp_ready;
  assign rsp_hit       = valid_q[tex_rsp_tag];
  // Only a response to an occupied entry frees it; a response to a free entry
  // is flagged but must not disturb a slot that may be allocated this cycle.
  assign rsp_free      = rsp_fire & rsp_hit;

  assign req_meta = '{wid: exe_wid, uuid: exe_uuid, rd: exe_rd, mask: exe_mask};

  always_comb begin
    valid_d = valid_q;
    if (rsp_free) valid_d[tex_rsp_tag] = 1'b0;
    // The allocated slot is free and the freed slot was valid, so these two
    // writes never target the same entry.
    if (req_fire) valid_d[free_tag] = 1'b1;

    cnt_d = cnt_q;
    if (req_fire && !rsp_free)      cnt_d = cnt_q + (TAG_W+1)'(1);
    else if (!req_fire && rsp_free) cnt_d = cnt_q - (TAG_W+1)'(1);

    commit_valid_d = commit_valid_q;
    if (rsp_fire)          commit_valid_d = 1'b1;
    else if (commit_ready) commit_valid_d = 1'b0;

    tag_err_d = tag_err_q | (rsp_fire & ~rsp_hit);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= '0;
      cnt_q          <= '0;
      commit_valid_q <= 1'b0;
      tag_err_q      <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      cnt_q          <= cnt_d;
      commit_valid_q <= commit_valid_d;
      tag_err_q      <= tag_err_d;
    end
  end

  // NOTE: the metadata table and commit payload carry no reset; they are only
  // observed behind a valid bit, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (req_fire) table_q[free_tag] <= req_meta;
    if (rsp_fire) begin
      // A response to a free entry still commits whatever metadata is there.
      commit_meta_q <= table_q[tex_rsp_tag];
      commit_data_q <= tex_rsp_texels;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_wid   = commit_meta_q.wid;
  assign commit_uuid  = commit_meta_q.uuid;
  assign commit_rd    = commit_meta_q.rd;
  assign commit_mask  = commit_meta_q.mask;
  assign commit_data  = commit_data_q;
  assign pending_cnt  = cnt_q;
  assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_tex_agent.sv
// tb_tex_agent: self-checking bench for tex_agent.
//
// A behavioural model keeps the tag table as an array of entries with valid
// flags; occupancy is the number of valid entries, the next tag is the lowest
// free entry, and the commit register is a single slot. Each scenario task
// drives stimulus, advances the model with the clock, and compares DUT
// outputs against the model or against fixed expected constants.
module tb_tex_agent;

  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 4;
  localparam int WID_W     = 2;
  localparam int UUID_W    = 44;
  localparam int RD_W      = 5;
  localparam int TAG_W     = 2;
  localparam int PKT_W     = WID_W + UUID_W + RD_W + NUM_LANES + NUM_LANES*32;

  logic         clk = 1'b0;
  logic         reset;
  logic         exe_valid;
  logic [1:0]   exe_wid;
  logic [43:0]  exe_uuid;
  logic [4:0]   exe_rd;
  logic [3:0]   exe_mask;
  logic [255:0] exe_coords;
  logic [15:0]  exe_lod;
  logic [0:0]   exe_stage;
  logic         exe_ready;
  logic         tex_req_valid;
  logic [3:0]   tex_req_mask;
  logic [255:0] tex_req_coords;
  logic [15:0]  tex_req_lod;
  logic [0:0]   tex_req_stage;
  logic [1:0]   tex_req_tag;
  logic         tex_req_ready;
  logic         tex_rsp_valid;
  logic [127:0] tex_rsp_texels;
  logic [1:0]   tex_rsp_tag;
  logic         tex_rsp_ready;
  logic         commit_valid;
  logic [1:0]   commit_wid;
  logic [43:0]  commit_uuid;
  logic [4:0]   commit_rd;
  logic [3:0]   commit_mask;
  logic [127:0] commit_data;
  logic         commit_ready;
  logic [2:0]   pending_cnt;
  logic         tag_err;

  tex_agent dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_wid(exe_wid), .exe_uuid(exe_uuid),
    .exe_rd(exe_rd), .exe_mask(exe_mask), .exe_coords(exe_coords),
    .exe_lod(exe_lod), .exe_stage(exe_stage), .exe_ready(exe_ready),
    .tex_req_valid(tex_req_valid), .tex_req_mask(tex_req_mask),
    .tex_req_coords(tex_req_coords), .tex_req_lod(tex_req_lod),
    .tex_req_stage(tex_req_stage), .tex_req_tag(tex_req_tag),
    .tex_req_ready(tex_req_ready),
    .tex_rsp_valid(tex_rsp_valid), .tex_rsp_texels(tex_rsp_texels),
    .tex_rsp_tag(tex_rsp_tag), .tex_rsp_ready(tex_rsp_ready),
    .commit_valid(commit_valid), .commit_wid(commit_wid),
    .commit_uuid(commit_uuid), .commit_rd(commit_rd),
    .commit_mask(commit_mask), .commit_data(commit_data),
    .commit_ready(commit_ready),
    .pending_cnt(pending_cnt), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  wid;
    logic [43:0] uuid;
    logic [4:0]  rd;
    logic [3:0]  mask;
  } meta_t;

  meta_t        m_meta [DEPTH];
  bit           m_valid [DEPTH];
  bit           m_cv;
  bit           m_err;
  bit           m_stale;
  meta_t        m_cmeta;
  logic [127:0] m_cdata;

  logic [PKT_W-1:0] act_pkt;
  assign act_pkt = {commit_wid, commit_uuid, commit_rd, commit_mask, commit_data};

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic int exp_free();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [PKT_W-1:0] exp_pkt();
    return {m_cmeta.wid, m_cmeta.uuid, m_cmeta.rd, m_cmeta.mask, m_cdata};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_cv = 1'b0; m_err = 1'b0; m_stale = 1'b0;
  endtask

  // Advance one clock; the model applies the handshake rules to the inputs
  // present just before the edge. Returns 1 ns after the edge.
  task automatic tick();
    bit           rf, pf;
    int           ft;
    meta_t        nm;
    int           rt;
    logic [127:0] tx;
    rf = exe_valid && tex_req_ready && (exp_cnt() < DEPTH);
    pf = tex_rsp_valid && (!m_cv || commit_ready);
    ft = exp_free();
    nm = '{wid: exe_wid, uuid: exe_uuid, rd: exe_rd, mask: exe_mask};
    rt = int'(tex_rsp_tag);
    tx = tex_rsp_texels;
    @(posedge clk);
    if (pf) begin
      m_cmeta = m_meta[rt];
      m_cdata = tx;
      m_cv    = 1'b1;
      if (m_valid[rt]) begin
        m_valid[rt] = 1'b0;
        m_stale     = 1'b0;
      end else begin
        m_err   = 1'b1;
        m_stale = 1'b1;
      end
    end else if (commit_ready) begin
      m_cv = 1'b0;
    end
    if (rf) begin
      m_meta[ft]  = nm;
      m_valid[ft] = 1'b1;
    end
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    exe_valid     = 1'b0;
    tex_rsp_valid = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] w, input logic [4:0] r,
                           input logic [3:0] m);
    exe_valid = 1'b1;
    exe_wid   = w;
    exe_rd    = r;
    exe_mask  = m;
    exe_uuid  = 44'({$urandom(), $urandom()});
    for (int i = 0; i < 8; i++) exe_coords[i*32 +: 32] = $urandom();
    exe_lod   = 16'($urandom());
    exe_stage = 1'($urandom());
  endtask

  task automatic drive_rnd_req();
    drive_req(2'($urandom()), 5'($urandom()), 4'($urandom()));
  endtask

  task automatic drive_rsp(input int tag);
    tex_rsp_valid = 1'b1;
    tex_rsp_tag   = 2'(tag);
    for (int i = 0; i < NUM_LANES; i++) tex_rsp_texels[i*32 +: 32] = $urandom();
  endtask

  // Return every outstanding entry in a random order, then let the last
  // commit drain.
  task automatic drain_all();
    int q[$];
    int j, t;
    commit_ready = 1'b1;
    exe_valid    = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) q.push_back(i);
    for (int i = q.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = q[i]; q[i] = q[j]; q[j] = t;
    end
    foreach (q[k]) begin
      drive_rsp(q[k]);
      tick();
    end
    idle();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    tex_req_ready = 1'b1;
    drive_rnd_req();
    #1;
    n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL reset.pending_cnt: got %0d expected 0", pending_cnt); end
    n_vec++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL reset.commit_valid: got %b expected 0", commit_valid); end
    n_vec++; if (tag_err !== 1'b0) begin n_err++; $display("FAIL reset.tag_err: got %b expected 0", tag_err); end
    n_vec++; if (exe_ready !== 1'b1) begin n_err++; $display("FAIL reset.exe_ready_hi: got %b expected 1", exe_ready); end
    n_vec++; if (tex_req_valid !== 1'b1) begin n_err++; $display("FAIL reset.tex_req_valid: got %b expected 1", tex_req_valid); end
    tex_req_ready = 1'b0;
    #1;
    n_vec++; if (exe_ready !== 1'b0) begin n_err++; $display("FAIL reset.exe_ready_lo: got %b expected 0", exe_ready); end
    idle();
    tex_req_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [43:0] uuid;
    drive_req(2'd2, 5'd7, 4'b1011);
    uuid = exe_uuid;
    #1;
    n_vec++; if (tex_req_valid !== 1'b1) begin n_err++; $display("FAIL single.req_valid: got %b expected 1", tex_req_valid); end
    n_vec++; if (tex_req_tag !== 2'd0) begin n_err++; $display("FAIL single.req_tag: got %0d expected 0", tex_req_tag); end
    n_vec++; if (tex_req_mask !== 4'b1011) begin n_err++; $display("FAIL single.req_mask: got %b expected 1011", tex_req_mask); end
    n_vec++; if ({tex_req_coords, tex_req_lod, tex_req_stage} !== {exe_coords, exe_lod, exe_stage})
      begin n_err++; $display("FAIL single.req_payload: got %h expected %h", {tex_req_coords, tex_req_lod, tex_req_stage}, {exe_coords, exe_lod, exe_stage}); end
    tick();
    idle();
    n_vec++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL single.pending_after_req: got %0d expected 1", pending_cnt); end
    tex_rsp_valid  = 1'b1;
    tex_rsp_tag    = 2'd0;
    tex_rsp_texels = 128'h000000A3_000000A2_000000A1_000000A0;
    #1;
    n_vec++; if (tex_rsp_ready !== 1'b1) begin n_err++; $display("FAIL single.rsp_ready: got %b expected 1", tex_rsp_ready); end
    tick();
    idle();
    n_vec++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL single.commit_valid: got %b expected 1", commit_valid); end
    n_vec++; if ({commit_wid, commit_rd, commit_mask} !== {2'd2, 5'd7, 4'b1011})
      begin n_err++; $display("FAIL single.commit_meta: got %h expected %h", {commit_wid, commit_rd, commit_mask}, {2'd2, 5'd7, 4'b1011}); end
    n_vec++; if (commit_uuid !== uuid) begin n_err++; $display("FAIL single.commit_uuid: got %h expected %h", commit_uuid, uuid); end
    n_vec++; if (commit_data !== 128'h000000A3_000000A2_000000A1_000000A0)
      begin n_err++; $display("FAIL single.commit_data: got %h expected 000000a3000000a2000000a1000000a0", commit_data); end
    n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL single.pending_after_rsp: got %0d expected 0", pending_cnt); end
    tick();
    n_vec++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL single.commit_drained: got %b expected 0", commit_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      drive_rnd_req();
      #1;
      if (i < 4) begin
        n_vec++; if (tex_req_tag !== 2'(i)) begin n_err++; $display("FAIL fill.tag%0d: got %0d expected %0d", i, tex_req_tag, i); end
        n_vec++; if (exe_ready !== 1'b1) begin n_err++; $display("FAIL fill.ready%0d: got %b expected 1", i, exe_ready); end
      end else begin
        n_vec++; if ({exe_ready, tex_req_valid} !== 2'b00) begin n_err++; $display("FAIL fill.held: got ready/valid %b expected 00", {exe_ready, tex_req_valid}); end
        n_vec++; if (pending_cnt !== 3'd4) begin n_err++; $display("FAIL fill.pending_full: got %0d expected 4", pending_cnt); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_out_of_order();
    int          order [4] = '{2, 0, 3, 1};
    logic [43:0] u [DEPTH];
    for (int i = 0; i < DEPTH; i++) u[i] = m_meta[i].uuid;
    commit_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_rsp(order[k]);
      // Once tags 2 and 0 are free, a new request must land on tag 0.
      if (k == 2) drive_rnd_req(); else exe_valid = 1'b0;
      #1;
      n_vec++; if (tex_rsp_ready !== 1'b1) begin n_err++; $display("FAIL ooo.rsp_ready%0d: got %b expected 1", k, tex_rsp_ready); end
      if (k == 2) begin
        n_vec++; if (tex_req_tag !== 2'd0) begin n_err++; $display("FAIL ooo.realloc_tag: got %0d expected 0", tex_req_tag); end
      end
      tick();
      n_vec++; if (commit_uuid !== u[order[k]]) begin n_err++; $display("FAIL ooo.uuid%0d: got %h expected %h", k, commit_uuid, u[order[k]]); end
      n_vec++; if (act_pkt !== exp_pkt()) begin n_err++; $display("FAIL ooo.pkt%0d: got %h expected %h", k, act_pkt, exp_pkt()); end
    end
    idle();
    tick();
    n_vec++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL ooo.pending: got %0d expected 1", pending_cnt); end
    drain_all();
  endtask

  task automatic test_alloc_free();
    drive_rnd_req(); tick();
    drive_rnd_req(); tick();
    drive_rnd_req();
    drive_rsp(0);
    #1;
    n_vec++; if (tex_req_tag !== 2'd2) begin n_err++; $display("FAIL allocfree.tag: got %0d expected 2", tex_req_tag); end
    tick();
    idle();
    n_vec++; if (pending_cnt !== 3'd2) begin n_err++; $display("FAIL allocfree.pending: got %0d expected 2", pending_cnt); end
    n_vec++; if (act_pkt !== exp_pkt()) begin n_err++; $display("FAIL allocfree.pkt: got %h expected %h", act_pkt, exp_pkt()); end
    drain_all();
  endtask

  task automatic test_full_free();
    for (int i = 0; i < 4; i++) begin drive_rnd_req(); tick(); end
    drive_rnd_req();
    drive_rsp(1);
    #1;
    n_vec++; if ({exe_ready, tex_req_valid} !== 2'b00) begin n_err++; $display("FAIL fullfree.same_cycle: got ready/valid %b expected 00", {exe_ready, tex_req_valid}); end
    tick();
    tex_rsp_valid = 1'b0;
    n_vec++; if (pending_cnt !== 3'd3) begin n_err++; $display("FAIL fullfree.pending3: got %0d expected 3", pending_cnt); end
    #1;
    n_vec++; if ({exe_ready, tex_req_tag} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL fullfree.retry: got ready/tag %h expected %h", {exe_ready, tex_req_tag}, {1'b1, 2'd1}); end
    tick();
    idle();
    n_vec++; if (pending_cnt !== 3'd4) begin n_err++; $display("FAIL fullfree.pending4: got %0d expected 4", pending_cnt); end
    drain_all();
  endtask

  task automatic test_backpressure();
    logic [PKT_W-1:0] snap;
    for (int i = 0; i < 3; i++) begin drive_rnd_req(); tick(); end
    idle();
    commit_ready = 1'b0;
    drive_rsp(0);
    tick();
    drive_rsp(1);
    snap = exp_pkt();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (tex_rsp_ready !== 1'b0) begin n_err++; $display("FAIL bp.rsp_ready%0d: got %b expected 0", c, tex_rsp_ready); end
      tick();
      n_vec++; if ({commit_valid, act_pkt} !== {1'b1, snap}) begin n_err++; $display("FAIL bp.stable%0d: got %h expected %h", c, {commit_valid, act_pkt}, {1'b1, snap}); end
    end
    n_vec++; if (pending_cnt !== 3'd2) begin n_err++; $display("FAIL bp.pending_stall: got %0d expected 2", pending_cnt); end
    commit_ready = 1'b1;
    #1;
    n_vec++; if (tex_rsp_ready !== 1'b1) begin n_err++; $display("FAIL bp.release: got %b expected 1", tex_rsp_ready); end
    tick();
    n_vec++; if ({commit_valid, act_pkt} !== {1'b1, exp_pkt()}) begin n_err++; $display("FAIL bp.drain1: got %h expected %h", {commit_valid, act_pkt}, {1'b1, exp_pkt()}); end
    drive_rsp(2);
    tick();
    idle();
    n_vec++; if ({commit_valid, act_pkt} !== {1'b1, exp_pkt()}) begin n_err++; $display("FAIL bp.drain2: got %h expected %h", {commit_valid, act_pkt}, {1'b1, exp_pkt()}); end
    n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL bp.pending_end: got %0d expected 0", pending_cnt); end
    tick();
    n_vec++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL bp.empty: got %b expected 0", commit_valid); end
  endtask

  task automatic test_tag_err();
    commit_ready = 1'b1;
    drive_rsp(1);
    tick();
    idle();
    n_vec++; if ({tag_err, commit_valid} !== 2'b11) begin n_err++; $display("FAIL tagerr.flag: got err/cv %b expected 11", {tag_err, commit_valid}); end
    n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL tagerr.pending: got %0d expected 0", pending_cnt); end
    drive_rnd_req(); tick();
    idle();
    drain_all();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (tag_err !== 1'b1) begin n_err++; $display("FAIL tagerr.sticky%0d: got %b expected 1", c, tag_err); end
    end
  endtask

  task automatic test_reset_mid();
    drive_rnd_req(); tick();
    drive_rnd_req(); tick();
    commit_ready = 1'b0;
    drive_rsp(0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    n_vec++; if ({pending_cnt, commit_valid, tag_err} !== 5'b000_0_0) begin n_err++; $display("FAIL rstmid.state: got cnt/cv/err %b expected 00000", {pending_cnt, commit_valid, tag_err}); end
    n_vec++; if ({exe_ready, tex_rsp_ready} !== 2'b11) begin n_err++; $display("FAIL rstmid.ready: got %b expected 11", {exe_ready, tex_rsp_ready}); end
    model_reset();
    commit_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_rnd_req();
    #1;
    n_vec++; if (tex_req_tag !== 2'd0) begin n_err++; $display("FAIL rstmid.tag0: got %0d expected 0", tex_req_tag); end
    tick();
    idle();
    n_vec++; if (pending_cnt !== 3'd1) begin n_err++; $display("FAIL rstmid.pending: got %0d expected 1", pending_cnt); end
    drain_all();
  endtask

  task automatic test_random();
    int  q[$];
    bit  nfull;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) drive_rnd_req(); else exe_valid = 1'b0;
      tex_req_ready = ($urandom_range(0, 3) != 0);
      commit_ready  = ($urandom_range(0, 9) < 7);
      q.delete();
      for (int i = 0; i < DEPTH; i++) if (m_valid[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 9) < 6) drive_rsp(q[$urandom_range(0, q.size() - 1)]);
      else tex_rsp_valid = 1'b0;
      nfull = (exp_cnt() < DEPTH);
      #1;
      n_vec++; if ({tex_req_valid, exe_ready} !== {exe_valid & nfull, tex_req_ready & nfull})
        begin n_err++; $display("FAIL rand.req_hs%0d: got %b expected %b", c, {tex_req_valid, exe_ready}, {exe_valid & nfull, tex_req_ready & nfull}); end
      if (nfull) begin
        n_vec++; if (tex_req_tag !== 2'(exp_free())) begin n_err++; $display("FAIL rand.tag%0d: got %0d expected %0d", c, tex_req_tag, exp_free()); end
      end
      n_vec++; if (tex_rsp_ready !== (!m_cv || commit_ready)) begin n_err++; $display("FAIL rand.rsp_ready%0d: got %b expected %b", c, tex_rsp_ready, (!m_cv || commit_ready)); end
      tick();
      n_vec++; if ({pending_cnt, commit_valid, tag_err} !== {3'(exp_cnt()), m_cv, m_err})
        begin n_err++; $display("FAIL rand.state%0d: got %b expected %b", c, {pending_cnt, commit_valid, tag_err}, {3'(exp_cnt()), m_cv, m_err}); end
      if (m_cv && !m_stale) begin
        n_vec++; if (act_pkt !== exp_pkt()) begin n_err++; $display("FAIL rand.pkt%0d: got %h expected %h", c, act_pkt, exp_pkt()); end
      end
    end
    idle();
    drain_all();
    n_vec++; if (pending_cnt !== 3'd0) begin n_err++; $display("FAIL rand.final_pending: got %0d expected 0", pending_cnt); end
  endtask

  initial begin
    reset          = 1'b0;
    exe_wid        = '0;
    exe_uuid       = '0;
    exe_rd         = '0;
    exe_mask       = '0;
    exe_coords     = '0;
    exe_lod        = '0;
    exe_stage      = '0;
    tex_req_ready  = 1'b0;
    tex_rsp_tag    = '0;
    tex_rsp_texels = '0;
    commit_ready   = 1'b1;
    idle();
    model_reset();

    test_reset();
    test_single();
    test_fill();
    test_out_of_order();
    test_alloc_free();
    test_full_free();
    test_backpressure();
    test_tag_err();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
